hash_request_issuer: RTL and testbench
======================================

Name: hash_request_issuer

Overview:
- Initiator side of the hash-table controller's operation interface.
- Accepts read/write/delete requests from the user side over a valid/ready handshake.
- Presents key and data to the table pipeline, waits for the memory read-outs to settle, then drives the operation code for exactly one commit cycle and captures the status flags and read data.
- Returns a single response per request over a valid/ready handshake. Sits between the user/host logic and the table controller.

Parameters:
- KEY_WIDTH, 2, key bits.
- DATA_WIDTH, 32, data bits.
- LATENCY, 2, cycles from key presentation until the table read-outs and the controller flags are valid (hash plus memory read). Must be ≥1.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_op_i  in  2  01=read, 10=write, 11=delete; 00 is illegal and is dropped.
- req_key_i  in  KEY_WIDTH  request key.
- req_data_i  in  DATA_WIDTH  write data.
- tbl_op_o  out  2  operation code to the controller.
- tbl_key_o  out  KEY_WIDTH  key to the hash units and controller.
- tbl_data_o  out  DATA_WIDTH  data to the controller.
- tbl_clk_en_o  out  1  table/CAM clock enable.
- tbl_read_data_i  in  DATA_WIDTH  controller read data.
- tbl_valid_i  in  1  controller valid.
- tbl_no_del_target_i  in  1  status flag from the controller.
- tbl_no_write_space_i  in  1  status flag from the controller.
- tbl_no_elem_found_i  in  1  status flag from the controller.
- tbl_key_present_i  in  1  status flag from the controller.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response accepted.
- resp_status_o  out  3  0=OK, 1=NOT_FOUND, 2=NO_DEL_TARGET, 3=KEY_PRESENT, 4=NO_SPACE, 7=PROTOCOL_ERR.
- resp_data_o  out  DATA_WIDTH  read data when status is OK on a read, else 0.
- stat_ok_o  out  CNT_WIDTH  count of successful operations, saturating.
- stat_fail_o  out  CNT_WIDTH  count of failed operations, saturating.

Behaviour:

States: IDLE, SETTLE, COMMIT, RESP.

Reset values:
- State goes to IDLE.
- All registered outputs are 0: tbl_op_o=00, tbl_key_o=0, tbl_data_o=0, resp_valid_o=0, resp_status_o=0, resp_data_o=0, stat_ok_o=0, stat_fail_o=0.
- tbl_clk_en_o=1.
- A reset mid-operation abandons the request; no commit cycle is issued.

IDLE:
- req_ready_o=1.
- On handshake with op≠00: latch op/key/data, drive tbl_key_o/tbl_data_o from the latch, keep tbl_op_o=00, load the settle counter with LATENCY-1, go to SETTLE.
- On handshake with op=00: consume the request, generate no response, stay in IDLE.

SETTLE:
- req_ready_o=0. tbl_op_o held at 00, so no write enables fire.
- Counter decrements each cycle; when it reaches 0, go to COMMIT.
- Total key-stable time before commit is LATENCY cycles.

COMMIT (exactly one cycle):
- tbl_op_o = latched op.
- Sample the flags and tbl_read_data_i at the end of this cycle; the table write/delete happens on this edge.
- Status priority:
  - tbl_valid_i=0 → PROTOCOL_ERR.
  - Read: NOT_FOUND if no_elem_found.
  - Write: KEY_PRESENT takes precedence over NO_SPACE.
  - Delete: NO_DEL_TARGET if no_del_target.
  - Otherwise OK.
- resp_data_o captures read data only for a successful read; otherwise 0.
- Update the counters: stat_ok_o on OK, stat_fail_o on any other status. Both saturate at all-ones.
- Go to RESP. tbl_op_o returns to 00 on the next cycle.

RESP:
- resp_valid_o=1; status and data are held stable until resp_ready_i.
- On handshake go to IDLE; resp_valid_o drops the next cycle.
- req_ready_o=0 during RESP.
- Minimum request-to-request spacing is LATENCY+3 cycles.

Other rules:
- Only one operation is in flight; requests are never reordered or merged.
- tbl_clk_en_o is 1 in every state, so the controller's CAM counter advances only on the COMMIT edge. The op is 00 in all other states, so no other edge changes it.
- resp_ready_i held low stalls indefinitely in RESP; the table stays idle.

Test Plan:
1. Reset, then write key=2 data=0xDEADBEEF (LATENCY=2), controller returning no flags → tbl_op_o=10 for exactly one cycle, 3 cycles after acceptance; response status 0, data 0; stat_ok_o=1.
2. Read key=2 with tbl_read_data_i=0xDEADBEEF at commit → status 0, resp_data_o=0xDEADBEEF; tbl_op_o=01 for one cycle only.
3. Write with both key_present and no_write_space high → status 3; stat_fail_o increments by 1. Delete with no_del_target high → status 2.
4. Hold resp_ready_i low for 10 cycles → resp_valid_o stays 1 with a stable payload, req_ready_o stays 0, tbl_op_o stays 00; releasing resp_ready_i gives req_ready_o=1 one cycle later.
5. Assert reset during SETTLE → no commit cycle occurs, resp_valid_o=0, counters are 0. Separately, a req_op_i=00 request produces no response.
6. Force stat_ok_o to 0xFFFF via 65535 OK operations (or a CNT_WIDTH=4 build with 16 operations) → the counter holds at the maximum.

Source files
------------

// File: rtl/hash_request_issuer.sv
// hash_request_issuer: issues one read/write/delete at a time to the hash-table
// controller. The key and data are held steady for LATENCY cycles so the hash and
// memory read-outs can settle. The op code is then driven for a single commit
// cycle, the controller flags are folded into one status code, and a response is
// returned to the requester.
module hash_request_issuer #(
   parameter int KEY_WIDTH  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [KEY_WIDTH-1:0]  req_key_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic [1:0]            tbl_op_o,
   output logic [KEY_WIDTH-1:0]  tbl_key_o,
   output logic [DATA_WIDTH-1:0] tbl_data_o,
   output logic                  tbl_clk_en_o,
   input  logic [DATA_WIDTH-1:0] tbl_read_data_i,
   input  logic                  tbl_valid_i,
   input  logic                  tbl_no_del_target_i,
   input  logic                  tbl_no_write_space_i,
   input  logic                  tbl_no_elem_found_i,
   input  logic                  tbl_key_present_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [2:0]            resp_status_o,
   output logic [DATA_WIDTH-1:0] resp_data_o,
   output logic [CNT_WIDTH-1:0]  stat_ok_o,
   output logic [CNT_WIDTH-1:0]  stat_fail_o
);

   localparam int SW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [SW-1:0]        SETTLE_INIT = SW'(LATENCY - 1);
   localparam logic [SW-1:0]        SETTLE_ONE  = SW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_DEL = 2'b11;

   localparam logic [2:0] ST_OK        = 3'd0;
   localparam logic [2:0] ST_NOT_FOUND = 3'd1;
   localparam logic [2:0] ST_NO_DEL    = 3'd2;
   localparam logic [2:0] ST_KEY_PRES  = 3'd3;
   localparam logic [2:0] ST_NO_SPACE  = 3'd4;
   localparam logic [2:0] ST_PROTO_ERR = 3'd7;

   typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, RESP} state_t;

   typedef struct packed {
      logic [1:0]            op;
      logic [KEY_WIDTH-1:0]  key;
      logic [DATA_WIDTH-1:0] data;
   } req_t;

   state_t         state, state_nxt;
   req_t           req_q;
   logic [SW-1:0]  settle_cnt;
   logic [2:0]     commit_status;
   logic           accept;

   // The CAM counter only moves on an edge with a non-zero op, so the clock
   // enable can stay high permanently.
   assign tbl_clk_en_o = 1'b1;
   assign tbl_key_o    = req_q.key;
   assign tbl_data_o   = req_q.data;
   assign accept       = req_valid_i && (req_op_i != OP_NOP);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and handshake ready
   always_comb begin
      state_nxt   = state;
      req_ready_o = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (accept) state_nxt = SETTLE;
         end
         SETTLE:  if (settle_cnt == '0) state_nxt = COMMIT;
         COMMIT:  state_nxt = RESP;
         RESP:    if (resp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Fold the controller flags into one status. A missing tbl_valid_i overrides
   // everything, and flags that do not belong to the current op are ignored.
   always_comb begin
      commit_status = ST_OK;
      if (!tbl_valid_i) begin
         commit_status = ST_PROTO_ERR;
      end else begin
         case (req_q.op)
            OP_RD:   if (tbl_no_elem_found_i) commit_status = ST_NOT_FOUND;
            OP_WR: begin
               if (tbl_key_present_i)         commit_status = ST_KEY_PRES;
               else if (tbl_no_write_space_i) commit_status = ST_NO_SPACE;
            end
            OP_DEL:  if (tbl_no_del_target_i) commit_status = ST_NO_DEL;
            default: commit_status = ST_OK;
         endcase
      end
   end

   // Request latch, settle counter, commit strobe, response and statistics.
   // tbl_op_o is registered, so it goes high on the edge that enters COMMIT and
   // drops on the edge that leaves it.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_q         <= '0;
         settle_cnt    <= '0;
         tbl_op_o      <= OP_NOP;
         resp_valid_o  <= 1'b0;
         resp_status_o <= ST_OK;
         resp_data_o   <= '0;
         stat_ok_o     <= '0;
         stat_fail_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_q      <= {req_op_i, req_key_i, req_data_i};
                  settle_cnt <= SETTLE_INIT;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) tbl_op_o   <= req_q.op;
               else                  settle_cnt <= settle_cnt - SETTLE_ONE;
            end
            COMMIT: begin
               tbl_op_o      <= OP_NOP;
               resp_valid_o  <= 1'b1;
               resp_status_o <= commit_status;
               resp_data_o   <= (req_q.op == OP_RD && commit_status == ST_OK) ?
                                tbl_read_data_i : '0;
               if (commit_status == ST_OK) begin
                  if (stat_ok_o != '1) stat_ok_o <= stat_ok_o + CNT_ONE;
               end else begin
                  if (stat_fail_o != '1) stat_fail_o <= stat_fail_o + CNT_ONE;
               end
            end
            RESP: if (resp_ready_i) resp_valid_o <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_request_issuer.sv
// Directed bench for hash_request_issuer (LATENCY=2, 4-bit counters so that
// saturation is reachable quickly). Expected values are hand-derived constants.
module tb_hash_request_issuer;

   localparam int KW  = 2;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int CW  = 4;

   // flag vector order: {valid, key_present, no_write_space, no_elem_found, no_del_target}
   localparam logic [4:0] F_V  = 5'b10000;
   localparam logic [4:0] F_KP = 5'b01000;
   localparam logic [4:0] F_NS = 5'b00100;
   localparam logic [4:0] F_NE = 5'b00010;
   localparam logic [4:0] F_ND = 5'b00001;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [1:0]    req_op_i = '0;
   logic [KW-1:0] req_key_i = '0;
   logic [DW-1:0] req_data_i = '0;
   logic [1:0]    tbl_op_o;
   logic [KW-1:0] tbl_key_o;
   logic [DW-1:0] tbl_data_o;
   logic          tbl_clk_en_o;
   logic [DW-1:0] tbl_read_data_i = '0;
   logic          tbl_valid_i = 1'b0;
   logic          tbl_no_del_target_i = 1'b0;
   logic          tbl_no_write_space_i = 1'b0;
   logic          tbl_no_elem_found_i = 1'b0;
   logic          tbl_key_present_i = 1'b0;
   logic          resp_valid_o;
   logic          resp_ready_i = 1'b0;
   logic [2:0]    resp_status_o;
   logic [DW-1:0] resp_data_o;
   logic [CW-1:0] stat_ok_o;
   logic [CW-1:0] stat_fail_o;

   int n_tests = 0;
   int n_fail  = 0;

   hash_request_issuer #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_key_i(req_key_i), .req_data_i(req_data_i),
      .tbl_op_o(tbl_op_o), .tbl_key_o(tbl_key_o), .tbl_data_o(tbl_data_o),
      .tbl_clk_en_o(tbl_clk_en_o), .tbl_read_data_i(tbl_read_data_i), .tbl_valid_i(tbl_valid_i),
      .tbl_no_del_target_i(tbl_no_del_target_i), .tbl_no_write_space_i(tbl_no_write_space_i),
      .tbl_no_elem_found_i(tbl_no_elem_found_i), .tbl_key_present_i(tbl_key_present_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_status_o(resp_status_o),
      .resp_data_o(resp_data_o), .stat_ok_o(stat_ok_o), .stat_fail_o(stat_fail_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [4:0] f, input logic [31:0] rd);
      {tbl_valid_i, tbl_key_present_i, tbl_no_write_space_i,
       tbl_no_elem_found_i, tbl_no_del_target_i} = f;
      tbl_read_data_i = rd;
   endtask

   // One full transaction with commit-timing and response checks.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [KW-1:0] key,
                         input logic [31:0] data, input logic [4:0] f, input logic [31:0] rd,
                         input logic [2:0] est, input logic [31:0] ed, input bit stall);
      int commits, commit_at, resp_at, bad;
      logic [1:0]    cop;
      logic [KW-1:0] ckey;
      logic [31:0]   cdata;
      commits = 0; commit_at = 0; resp_at = 0; bad = 0;
      cop = '0; ckey = '0; cdata = '0;
      set_flags(f, rd);
      resp_ready_i = !stall;
      chk({tag, " req_ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_data_i = data;
      tick();
      req_valid_i = 1'b0; req_op_i = 2'b00; req_data_i = 32'h5555_AAAA;
      for (int n = 1; n <= 20; n++) begin
         if (tbl_op_o != 2'b00) begin
            commits++; commit_at = n; cop = tbl_op_o; ckey = tbl_key_o; cdata = tbl_data_o;
         end
         if (resp_valid_o) begin resp_at = n; break; end
         tick();
      end
      chk({tag, " commit_cycles"}, 32'(commits), 32'd1);
      chk({tag, " commit_at"}, 32'(commit_at), 32'(LAT + 1));
      chk({tag, " commit_op"}, 32'(cop), 32'(op));
      chk({tag, " commit_key"}, 32'(ckey), 32'(key));
      chk({tag, " commit_data"}, cdata, data);
      chk({tag, " resp_at"}, 32'(resp_at), 32'(LAT + 2));
      chk({tag, " resp_status"}, 32'(resp_status_o), 32'(est));
      chk({tag, " resp_data"}, resp_data_o, ed);
      chk({tag, " ready_in_resp"}, 32'(req_ready_o), 32'd0);
      if (stall) begin
         for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid_o !== 1'b1 || resp_status_o !== est || resp_data_o !== ed ||
                req_ready_o !== 1'b0 || tbl_op_o !== 2'b00) bad++;
         end
         chk({tag, " stall_hold_errors"}, 32'(bad), 32'd0);
         resp_ready_i = 1'b1;
      end
      tick();
      resp_ready_i = 1'b0;
      chk({tag, " resp_valid_after_ack"}, 32'(resp_valid_o), 32'd0);
      chk({tag, " ready_after_ack"}, 32'(req_ready_o), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   initial begin
      int bad;
      #1;
      do_reset();

      // reset state
      chk("rst tbl_op", 32'(tbl_op_o), 32'd0);
      chk("rst tbl_key", 32'(tbl_key_o), 32'd0);
      chk("rst tbl_data", tbl_data_o, 32'd0);
      chk("rst clk_en", 32'(tbl_clk_en_o), 32'd1);
      chk("rst resp_valid", 32'(resp_valid_o), 32'd0);
      chk("rst resp_status", 32'(resp_status_o), 32'd0);
      chk("rst resp_data", resp_data_o, 32'd0);
      chk("rst stat_ok", 32'(stat_ok_o), 32'd0);
      chk("rst stat_fail", 32'(stat_fail_o), 32'd0);
      chk("rst req_ready", 32'(req_ready_o), 32'd1);

      // successful write and read-back
      run_op("wr_ok", 2'b10, 2'd2, 32'hDEADBEEF, F_V, 32'h0, 3'd0, 32'h0, 1'b0);
      chk("wr_ok stat_ok", 32'(stat_ok_o), 32'd1);
      run_op("rd_ok", 2'b01, 2'd2, 32'h0, F_V, 32'hDEADBEEF, 3'd0, 32'hDEADBEEF, 1'b0);
      chk("rd_ok stat_ok", 32'(stat_ok_o), 32'd2);
      // flags not belonging to the op are ignored
      run_op("rd_xflags", 2'b01, 2'd1, 32'h0, F_V | F_KP | F_NS | F_ND, 32'hCAFEF00D,
             3'd0, 32'hCAFEF00D, 1'b0);
      run_op("del_xflags", 2'b11, 2'd3, 32'h0, F_V | F_NE | F_KP, 32'h77, 3'd0, 32'h0, 1'b0);
      chk("xflags stat_ok", 32'(stat_ok_o), 32'd4);

      // failure statuses
      run_op("wr_kp_ns", 2'b10, 2'd1, 32'h11, F_V | F_KP | F_NS, 32'h0, 3'd3, 32'h0, 1'b0);
      chk("wr_kp_ns stat_fail", 32'(stat_fail_o), 32'd1);
      run_op("del_nodel", 2'b11, 2'd2, 32'h0, F_V | F_ND, 32'h0, 3'd2, 32'h0, 1'b0);
      run_op("rd_nf", 2'b01, 2'd3, 32'h0, F_V | F_NE, 32'h1234, 3'd1, 32'h0, 1'b0);
      run_op("wr_ns", 2'b10, 2'd3, 32'h22, F_V | F_NS, 32'h0, 3'd4, 32'h0, 1'b0);
      run_op("wr_noval", 2'b10, 2'd0, 32'h33, F_KP, 32'h0, 3'd7, 32'h0, 1'b0);
      run_op("rd_noval", 2'b01, 2'd2, 32'h0, 5'b00000, 32'hDEADBEEF, 3'd7, 32'h0, 1'b0);
      chk("fails stat_fail", 32'(stat_fail_o), 32'd6);
      chk("fails stat_ok", 32'(stat_ok_o), 32'd4);

      // response back-pressure
      run_op("rd_stall", 2'b01, 2'd1, 32'h0, F_V, 32'hA5A5_0F0F, 3'd0, 32'hA5A5_0F0F, 1'b1);
      chk("stall stat_ok", 32'(stat_ok_o), 32'd5);

      // reset during SETTLE abandons the request
      set_flags(F_V, 32'h0);
      req_valid_i = 1'b1; req_op_i = 2'b10; req_key_i = 2'd1; req_data_i = 32'h99;
      tick();
      req_valid_i = 1'b0; req_op_i = 2'b00;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (tbl_op_o !== 2'b00 || resp_valid_o !== 1'b0) bad++;
         tick();
      end
      chk("rst_settle activity", 32'(bad), 32'd0);
      chk("rst_settle stat_ok", 32'(stat_ok_o), 32'd0);
      chk("rst_settle stat_fail", 32'(stat_fail_o), 32'd0);
      chk("rst_settle req_ready", 32'(req_ready_o), 32'd1);

      // op 00 is consumed silently
      req_valid_i = 1'b1; req_op_i = 2'b00; req_key_i = 2'd2; req_data_i = 32'h44;
      tick();
      req_valid_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (tbl_op_o !== 2'b00 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) bad++;
         tick();
      end
      chk("nop activity", 32'(bad), 32'd0);

      // saturation of the 4-bit OK counter
      for (int i = 0; i < 15; i++)
         run_op("sat", 2'b10, 2'(i), 32'(i), F_V, 32'h0, 3'd0, 32'h0, 1'b0);
      chk("sat stat_ok_15", 32'(stat_ok_o), 32'd15);
      run_op("sat16", 2'b11, 2'd0, 32'h0, F_V, 32'h0, 3'd0, 32'h0, 1'b0);
      chk("sat stat_ok_16", 32'(stat_ok_o), 32'd15);
      chk("sat stat_fail", 32'(stat_fail_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
